// File: rtl/sequence_controller.sv
// sequence_controller: 8-phase instruction sequencer and per-phase control strobe decoder
module sequence_controller #(
   parameter int OP_WIDTH = 3
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                RUN,
   input  logic [OP_WIDTH-1:0] OPCODE,
   input  logic                ZERO,
   output logic [2:0]          PHASE,
   output logic                MEM_RD,
   output logic                MEM_WR,
   output logic                DATA_E,
   output logic                LOAD_IR,
   output logic                LOAD_AC,
   output logic                PC_ENABLE,
   output logic                PC_LOAD,
   output logic                HALT
);
   if (OP_WIDTH != 3) begin : g_bad_width
      $error("sequence_controller: OP_WIDTH must be 3");
   end
   typedef enum logic [2:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
   } phase_e;
   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;
   phase_e phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   active, halt_now, alu_op, is_hlt, is_skz, is_sto, is_jmp;
   // next-state: advance while running, latch halt when HLT reaches OP_ADDR
   always_comb begin
      active   = RUN && !halted_q;
      is_hlt   = OPCODE == OP_HLT;
      is_skz   = OPCODE == OP_SKZ;
      is_sto   = OPCODE == OP_STO;
      is_jmp   = OPCODE == OP_JMP;
      alu_op   = !is_hlt && !is_skz && !is_sto && !is_jmp;
      halt_now = active && phase_q == OP_ADDR && is_hlt;
      halted_d = halted_q || halt_now;
      phase_d  = (active && !halt_now) ? phase_e'(phase_q + 3'd1) : phase_q;
   end
   // state register; reset aborts any instruction and clears halt
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end
   // strobe decode from the registered phase and the current opcode/flag
   always_comb begin
      PHASE     = phase_q;
      HALT      = halted_q || halt_now;
      MEM_RD    = active && (phase_q inside {INST_FETCH, INST_LOAD, IDLE} ||
                             (phase_q inside {OP_FETCH, ALU_OP, STORE} && alu_op));
      LOAD_IR   = active && phase_q inside {INST_LOAD, IDLE};
      LOAD_AC   = active && phase_q == STORE && alu_op;
      MEM_WR    = active && phase_q == STORE && is_sto;
      DATA_E    = active && phase_q inside {ALU_OP, STORE} && is_sto;
      PC_LOAD   = active && phase_q == STORE && is_jmp;
      PC_ENABLE = active && ((phase_q == OP_ADDR && !is_hlt) ||
                             (phase_q == ALU_OP && is_skz && ZERO) ||
                             (phase_q == STORE && is_jmp));
   end
endmodule

// File: tb/tb_sequence_controller.sv
// tb_sequence_controller: directed and random stimulus checked against a behavioural model
module tb_sequence_controller;
   logic       CLOCK = 1'b0;
   logic       RESET = 1'b0;
   logic       RUN = 1'b0;
   logic [2:0] OPCODE = 3'd0;
   logic       ZERO = 1'b0;
   logic [2:0] PHASE;
   logic       MEM_RD, MEM_WR, DATA_E, LOAD_IR, LOAD_AC, PC_ENABLE, PC_LOAD, HALT;
   int         n_vec = 0;
   int         n_err = 0;
   int         m_ph = 0;
   bit         m_halt = 1'b0;
   bit         known = 1'b0;

   sequence_controller #(.OP_WIDTH(3)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .OPCODE(OPCODE), .ZERO(ZERO),
      .PHASE(PHASE), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .DATA_E(DATA_E),
      .LOAD_IR(LOAD_IR), .LOAD_AC(LOAD_AC), .PC_ENABLE(PC_ENABLE),
      .PC_LOAD(PC_LOAD), .HALT(HALT)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // expected {PHASE, MEM_RD, MEM_WR, DATA_E, LOAD_IR, LOAD_AC, PC_ENABLE, PC_LOAD, HALT}
   function automatic logic [10:0] model_out(int ph, bit h, bit run, int op, bit z);
      bit act, alu, rd, wr, de, ir, ac, pe, pl, ht;
      act = run && !h;
      alu = op >= 2 && op <= 5;
      {rd, wr, de, ir, ac, pe, pl} = '0;
      ht = h || (act && ph == 4 && op == 0);
      if (act) begin
         case (ph)
            1: rd = 1;
            2, 3: begin rd = 1; ir = 1; end
            4: pe = op != 0;
            5: rd = alu;
            6: begin rd = alu; pe = op == 1 && z; de = op == 6; end
            7: begin
               rd = alu; ac = alu;
               wr = op == 6; de = op == 6;
               pe = op == 7; pl = op == 7;
            end
            default: ;
         endcase
      end
      return {3'(ph), rd, wr, de, ir, ac, pe, pl, ht};
   endfunction

   task automatic step(input logic rst, input logic run, input logic [2:0] op, input logic z);
      @(negedge CLOCK);
      RESET = rst; RUN = run; OPCODE = op; ZERO = z;
      #1;
      if (known) begin
         check($sformatf("ph%0d_op%0d_run%0d_z%0d", m_ph, op, run, z),
               {PHASE, MEM_RD, MEM_WR, DATA_E, LOAD_IR, LOAD_AC, PC_ENABLE, PC_LOAD, HALT},
               model_out(m_ph, m_halt, run, int'(op), z));
         check("pc_load_without_enable", 11'(PC_LOAD & ~PC_ENABLE), 11'd0);
         check("rd_wr_overlap", 11'(MEM_RD & MEM_WR), 11'd0);
      end
      @(posedge CLOCK);
      if (!rst) begin
         m_ph = 0; m_halt = 0; known = 1;
      end else if (run && !m_halt) begin
         if (m_ph == 4 && op == 0) m_halt = 1;
         else m_ph = (m_ph + 1) % 8;
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic z, input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 1, op, z);
   endtask

   initial begin
      int guard;
      step(0, 1, 3'd2, 0);
      step(0, 1, 3'd2, 0);
      run_op(3'd2, 0, 9);
      run_op(3'd7, 0, 8);
      run_op(3'd1, 1, 8);
      run_op(3'd1, 0, 8);
      run_op(3'd6, 0, 8);
      step(0, 1, 3'd0, 0);
      run_op(3'd0, 0, 5);
      for (int i = 0; i < 20; i++) step(1, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)));
      check("halt_held", {PHASE, 7'd0, HALT}, {3'd4, 7'd0, 1'b1});
      step(0, 1, 3'd2, 0);
      step(1, 0, 3'd2, 0);
      check("after_reset", {PHASE, 7'd0, HALT}, 11'd0);
      guard = 0;
      while (m_ph != 5 && guard < 16) begin step(1, 1, 3'd2, 0); guard++; end
      check("reach_phase5", 11'(m_ph), 11'd5);
      for (int i = 0; i < 3; i++) step(1, 0, 3'd0, 1);
      step(1, 1, 3'd2, 0);
      step(0, 1, 3'd2, 0);
      step(1, 1, 3'd2, 0);
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(49) != 0), 1'($urandom_range(4) != 0),
              3'($urandom_range(7)), 1'($urandom_range(1)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
